// File: rtl/conv_stream_controller_pkg.sv
// Shared types and sizing helpers for the convolver stream controller.
// The default-size localparams describe the standard 28x28 / 5x5 build.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_IMAGE_SIZE   = 28;
    localparam int DEF_KERNEL_SIZE  = 5;
    localparam int DEF_PIPE_LATENCY = 1;

    localparam int OUT_SIZE = DEF_IMAGE_SIZE - DEF_KERNEL_SIZE + 1;
    localparam int POS_W    = $clog2(DEF_IMAGE_SIZE);
    localparam int DL_DEPTH = DEF_PIPE_LATENCY + 1;

    // Row/column counter width; never narrower than one bit.
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_stream_controller_valid_delay_line.sv
// Two-bit tag shift register ({last_tag, valid_tag}) that keeps window
// qualifiers aligned with the convolver result bus.
module valid_delay_line
    import conv_pkg::*;
#(
    parameter int DEPTH = DL_DEPTH
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] shift_tag,
    output logic [1:0] tail_tag
);

    logic [1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= 2'b00;
        end else begin
            stage[0] <= shift_tag;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tail_tag = stage[DEPTH-1];

endmodule

// File: rtl/conv_stream_controller.sv
// Frame sequencer between the pixel front end and the 2-D convolver:
// forwards accepted pixels and qualifies results from in-image windows.
module conv_stream_controller
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_SIZE  = 5,
    parameter int IMAGE_SIZE   = 28,
    parameter int PIPE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    output logic                  in_ready,
    output logic                  conv_write,
    output logic [DATA_WIDTH-1:0] conv_pixel,
    input  logic [DATA_WIDTH-1:0] conv_result,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PW           = pos_width(IMAGE_SIZE);
    localparam int TAG_DEPTH    = PIPE_LATENCY + 1;
    // Tag line, output register, then one exit cycle: done trails the last result by two.
    localparam int DRAIN_CYCLES = PIPE_LATENCY + 3;
    localparam int DW           = $clog2(DRAIN_CYCLES) + 1;

    localparam logic [PW-1:0] LAST_POS  = PW'(IMAGE_SIZE - 1);
    localparam logic [PW-1:0] WIN_POS   = PW'(KERNEL_SIZE - 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_CYCLES - 1);

    state_t        state, state_next;
    logic [PW-1:0] row, col;
    logic [DW-1:0] drain_cnt;
    logic          accept;
    logic          valid_tag_p0, last_tag_p0;
    logic [1:0]    tag_shift, tag_tail;

    assign accept       = in_valid && (state == STREAM);
    assign valid_tag_p0 = (row >= WIN_POS) && (col >= WIN_POS);
    assign last_tag_p0  = (row == LAST_POS) && (col == LAST_POS);
    assign tag_shift    = accept ? {last_tag_p0, valid_tag_p0} : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:   if (start) state_next = STREAM;
            STREAM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_tag_p0) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_END) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                row <= '0;
                col <= '0;
            end else if (accept) begin
                if (col == LAST_POS) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    valid_delay_line #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk       (clk),
        .clear     (reset),
        .shift_tag (tag_shift),
        .tail_tag  (tag_tail)
    );

    // p1: registered write to the convolver; p2: qualified result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_write <= 1'b0;
            conv_pixel <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            conv_write <= accept;
            if (accept) conv_pixel <= in_pixel;
            out_valid <= tag_tail[0];
            out_last  <= tag_tail[0] & tag_tail[1];
            if (tag_tail[0]) out_data <= conv_result;
        end
    end

endmodule
